// File: rtl/bus_dest_loader_if.sv
// Write-request handshake into the bus destination loader.
// The requester drives the master side and the loader drives the slave side.
interface bus_dest_loader_if #(
  parameter int BUS_W = 24,
  parameter int SEL_W = 4
) ();
  logic [BUS_W-1:0] bus_in;
  logic             wr_valid;
  logic [SEL_W-1:0] wr_sel;
  logic             wr_ready;

  modport master (output bus_in, output wr_valid, output wr_sel, input wr_ready);
  modport slave  (input bus_in, input wr_valid, input wr_sel, output wr_ready);
endinterface

// File: rtl/bus_dest_loader.sv
// Write side of the datapath bus: loads a bus word into the selected register,
// or issues a multi-cycle byte write to data memory. Also auto-increments pc/ar.
//
// state | meaning
// IDLE  | ready for a write request
// MEMWR | holding dm_we/dm_addr/dm_wdata for MEM_LAT cycles
module bus_dest_loader #(
  parameter int BUS_W   = 24,
  parameter int SEL_W   = 4,
  parameter int MEM_LAT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  bus_dest_loader_if.slave   wr,
  input  logic               inc_pc,
  input  logic               inc_ar,
  output logic [15:0]        pc,
  output logic [15:0]        ir,
  output logic [15:0]        ar,
  output logic [23:0]        ac,
  output logic [7:0]         x,
  output logic [7:0]         y,
  output logic [7:0]         z,
  output logic [15:0]        r,
  output logic [7:0]         r1,
  output logic [23:0]        r2,
  output logic [15:0]        r3,
  output logic               dm_we,
  output logic [15:0]        dm_addr,
  output logic [7:0]         dm_wdata,
  output logic               sel_err
);

  typedef enum logic {IDLE, MEMWR} state_t;

  localparam logic [SEL_W-1:0] SEL_PC  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_IR  = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_AR  = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_AC  = SEL_W'(4);
  localparam logic [SEL_W-1:0] SEL_X   = SEL_W'(5);
  localparam logic [SEL_W-1:0] SEL_Y   = SEL_W'(6);
  localparam logic [SEL_W-1:0] SEL_Z   = SEL_W'(7);
  localparam logic [SEL_W-1:0] SEL_R   = SEL_W'(8);
  localparam logic [SEL_W-1:0] SEL_R1  = SEL_W'(9);
  localparam logic [SEL_W-1:0] SEL_R2  = SEL_W'(10);
  localparam logic [SEL_W-1:0] SEL_R3  = SEL_W'(11);
  localparam logic [SEL_W-1:0] SEL_DM  = SEL_W'(12);
  localparam logic [SEL_W-1:0] SEL_UND = SEL_W'(13);
  localparam logic [3:0]       CNT_INIT = 4'(MEM_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept;
  logic       mem_start;

  // wr_ready is deliberately gated by rst_n so it drops the moment reset asserts
  assign wr.wr_ready = (state_q == IDLE) && rst_n;
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign mem_start   = accept && (wr.wr_sel == SEL_DM);
  assign dm_we       = (state_q == MEMWR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_start) begin
          state_d = MEMWR;
          cnt_d   = CNT_INIT;
        end
      end
      MEMWR: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= '0;
      ir       <= '0;
      ar       <= '0;
      ac       <= '0;
      x        <= '0;
      y        <= '0;
      z        <= '0;
      r        <= '0;
      r1       <= '0;
      r2       <= '0;
      r3       <= '0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      sel_err  <= 1'b0;
    end else begin
      sel_err <= accept && (wr.wr_sel >= SEL_UND);

      // a bus write to pc/ar takes priority over a same-cycle increment
      if (accept && wr.wr_sel == SEL_PC) pc <= wr.bus_in[15:0];
      else if (inc_pc)                   pc <= pc + 16'd1;

      if (accept && wr.wr_sel == SEL_AR) ar <= wr.bus_in[15:0];
      else if (inc_ar)                   ar <= ar + 16'd1;

      if (mem_start) begin
        dm_addr  <= ar;
        dm_wdata <= wr.bus_in[7:0];
      end

      if (accept) begin
        case (wr.wr_sel)
          SEL_IR:  ir <= wr.bus_in[15:0];
          SEL_AC:  ac <= wr.bus_in[23:0];
          SEL_X:   x  <= wr.bus_in[7:0];
          SEL_Y:   y  <= wr.bus_in[7:0];
          SEL_Z:   z  <= wr.bus_in[7:0];
          SEL_R:   r  <= wr.bus_in[15:0];
          SEL_R1:  r1 <= wr.bus_in[7:0];
          SEL_R2:  r2 <= wr.bus_in[23:0];
          SEL_R3:  r3 <= wr.bus_in[15:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_dest_loader.sv
// Randomized and directed bench for bus_dest_loader against a cycle-level
// reference model that tracks registers, memory-write busy time and sel_err.
module tb_bus_dest_loader;
  localparam int MEM_LAT = 3;

  typedef logic [186:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inc_pc = 1'b0;
  logic inc_ar = 1'b0;
  logic [15:0] pc, ir, ar, r, r3, dm_addr;
  logic [23:0] ac, r2;
  logic [7:0]  x, y, z, r1, dm_wdata;
  logic        dm_we, sel_err;

  int errors = 0;
  int checks = 0;

  bus_dest_loader_if #(.BUS_W(24), .SEL_W(4)) wif ();

  bus_dest_loader #(.BUS_W(24), .SEL_W(4), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wif), .inc_pc(inc_pc), .inc_ar(inc_ar),
    .pc(pc), .ir(ir), .ar(ar), .ac(ac), .x(x), .y(y), .z(z), .r(r),
    .r1(r1), .r2(r2), .r3(r3), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  // reference model
  logic [15:0] m_pc, m_ir, m_ar, m_r, m_r3, m_dm_addr;
  logic [23:0] m_ac, m_r2;
  logic [7:0]  m_x, m_y, m_z, m_r1, m_dm_wdata;
  logic        m_sel_err, m_live;
  int          m_busy;

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_ar = 0; m_r = 0; m_r3 = 0; m_dm_addr = 0;
    m_ac = 0; m_r2 = 0; m_x = 0; m_y = 0; m_z = 0; m_r1 = 0; m_dm_wdata = 0;
    m_sel_err = 0; m_live = 0; m_busy = 0;
  endtask

  task automatic model_edge(input logic v, input logic [3:0] s, input logic [23:0] d,
                            input logic ip, input logic ia);
    bit acc;
    acc = v && m_live && (m_busy == 0);
    m_sel_err = acc && (s >= 4'd13);
    if (m_busy > 0) m_busy--;
    else if (acc && s == 4'd12) begin
      m_busy = MEM_LAT;
      m_dm_addr = m_ar;
      m_dm_wdata = d[7:0];
    end
    if (acc && s == 4'd1) m_pc = d[15:0];
    else if (ip) m_pc = m_pc + 16'd1;
    if (acc && s == 4'd3) m_ar = d[15:0];
    else if (ia) m_ar = m_ar + 16'd1;
    if (acc) begin
      case (s)
        4'd2:  m_ir = d[15:0];
        4'd4:  m_ac = d;
        4'd5:  m_x  = d[7:0];
        4'd6:  m_y  = d[7:0];
        4'd7:  m_z  = d[7:0];
        4'd8:  m_r  = d[15:0];
        4'd9:  m_r1 = d[7:0];
        4'd10: m_r2 = d;
        4'd11: m_r3 = d[15:0];
        default: ;
      endcase
    end
  endtask

  function automatic vec_t exp_vec();
    return {m_pc, m_ir, m_ar, m_ac, m_x, m_y, m_z, m_r, m_r1, m_r2, m_r3,
            (m_busy > 0), m_dm_addr, m_dm_wdata, m_sel_err, (m_live && m_busy == 0)};
  endfunction

  function automatic vec_t dut_vec();
    return {pc, ir, ar, ac, x, y, z, r, r1, r2, r3,
            dm_we, dm_addr, dm_wdata, sel_err, wif.wr_ready};
  endfunction

  // drive at the falling edge, let the rising edge happen, return at the next falling edge
  task automatic tick(input logic v, input logic [3:0] s, input logic [23:0] d,
                      input logic ip, input logic ia);
    wif.wr_valid = v; wif.wr_sel = s; wif.bus_in = d; inc_pc = ip; inc_ar = ia;
    @(posedge clk);
    model_edge(v, s, d, ip, ia);
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_state: got %h want %h", dut_vec(), exp_vec());
    end
    rst_n = 1'b1;
    m_live = 1;
    #1;
    checks++;
    if (wif.wr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", wif.wr_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    tick(1, 4'd4, 24'hABCDEF, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec() || ac !== 24'hABCDEF) begin
      errors++; $display("FAIL load_ac: got %h want %h", dut_vec(), exp_vec());
    end
    tick(1, 4'd5, 24'h123456, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec() || x !== 8'h56) begin
      errors++; $display("FAIL load_x: got x=%h want 56", x);
    end
    tick(0, 4'd0, 24'h0, 0, 0);
  endtask

  task automatic test_truncation();
    for (int s = 1; s <= 11; s++) begin
      tick(1, 4'(s), 24'hFFFFFF, 0, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL trunc_code%0d: got %h want %h", s, dut_vec(), exp_vec());
      end
    end
    tick(0, 4'd0, 24'h0, 0, 0);
    checks++;
    if ({pc, ir, ar, r, r3} !== {5{16'hFFFF}} || {x, y, z, r1} !== {4{8'hFF}} ||
        {ac, r2} !== {2{24'hFFFFFF}}) begin
      errors++; $display("FAIL trunc_all: got %h", dut_vec());
    end
  endtask

  task automatic test_memwr();
    int we_cnt;
    tick(1, 4'd3, 24'h000040, 0, 0);
    tick(1, 4'd12, 24'h0000A5, 0, 0);
    we_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL memwr_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (dm_we) begin
        we_cnt++;
        checks++;
        if (dm_addr !== 16'h0040 || dm_wdata !== 8'hA5 || wif.wr_ready !== 1'b0) begin
          errors++; $display("FAIL memwr_hold: got addr=%h data=%h rdy=%b want 0040 a5 0",
                             dm_addr, dm_wdata, wif.wr_ready);
        end
      end
      tick(1, 4'd4, 24'h000777, 0, 0);
    end
    checks++;
    if (we_cnt != MEM_LAT || ac !== 24'h000777) begin
      errors++; $display("FAIL memwr_len: got we=%0d ac=%h want %0d 000777", we_cnt, ac, MEM_LAT);
    end
    tick(0, 4'd0, 24'h0, 0, 0);
  endtask

  task automatic test_increments();
    tick(1, 4'd1, 24'h00FFFF, 0, 0);
    tick(0, 4'd0, 24'h0, 1, 0);
    checks++;
    if (dut_vec() !== exp_vec() || pc !== 16'h0000) begin
      errors++; $display("FAIL pc_wrap: got %h want 0000", pc);
    end
    tick(1, 4'd1, 24'h001234, 1, 0);
    checks++;
    if (dut_vec() !== exp_vec() || pc !== 16'h1234) begin
      errors++; $display("FAIL pc_write_wins: got %h want 1234", pc);
    end
    tick(1, 4'd3, 24'h000010, 0, 0);
    tick(1, 4'd12, 24'h0000C3, 0, 1);
    checks++;
    if (dut_vec() !== exp_vec() || dm_addr !== 16'h0010 || ar !== 16'h0011) begin
      errors++; $display("FAIL dm_inc_ar: got addr=%h ar=%h want 0010 0011", dm_addr, ar);
    end
    for (int i = 0; i < MEM_LAT + 1; i++) begin
      tick(0, 4'd0, 24'h0, 1, 1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL inc_in_memwr%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_undef();
    tick(1, 4'd14, 24'($urandom), 0, 0);
    checks++;
    if (dut_vec() !== exp_vec() || sel_err !== 1'b1 || wif.wr_ready !== 1'b1) begin
      errors++; $display("FAIL undef_pulse: got %h want %h", dut_vec(), exp_vec());
    end
    tick(0, 4'd0, 24'h0, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec() || sel_err !== 1'b0) begin
      errors++; $display("FAIL undef_clear: got sel_err=%b want 0", sel_err);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom % 2) == 0, 4'($urandom % 16), 24'($urandom),
           ($urandom % 4) == 0, ($urandom % 4) == 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    for (int i = 0; i < MEM_LAT + 1; i++) tick(0, 4'd0, 24'h0, 0, 0);
  endtask

  task automatic test_reset_mid();
    tick(1, 4'd12, 24'h00005A, 0, 0);
    tick(0, 4'd0, 24'h0, 0, 0);
    checks++;
    if (dm_we !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got dm_we=%b want 1", dm_we);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== exp_vec() || dm_we !== 1'b0) begin
      errors++; $display("FAIL mid_reset_async: got %h want %h", dut_vec(), exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_live = 1;
    @(posedge clk);
    #1;
    checks++;
    if (wif.wr_ready !== 1'b1 || dm_we !== 1'b0) begin
      errors++; $display("FAIL mid_release: got rdy=%b we=%b want 1 0", wif.wr_ready, dm_we);
    end
    @(negedge clk);
    tick(1, 4'd8, 24'h00BEEF, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL mid_after: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  initial begin
    wif.wr_valid = 1'b0;
    wif.wr_sel = '0;
    wif.bus_in = '0;
    test_reset();
    test_basic_load();
    test_truncation();
    test_memwr();
    test_increments();
    test_undef();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
